// File: rtl/mux_rr_sched.sv
// mux_rr_sched: 3-port round-robin burst mux (clk, rst_n, req/port_a..c in; gnt/sel/out_data/out_valid out)
module mux_rr_sched #(
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [DW-1:0] port_a,
  input  logic [DW-1:0] port_b,
  input  logic [DW-1:0] port_c,
  output logic [2:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);
  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel_n, p1, p2, pick;
  logic [3:0] cnt, cnt_n;
  logic own_req, other, last;
  assign p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
  assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
  assign pick = req[ptr] ? ptr : req[p1] ? p1 : p2;
  assign gnt = sel == 2'd3 ? 3'b000 : 3'b001 << sel;
  assign own_req = |(gnt & req);
  assign other = |(req & ~gnt);
  assign last = cnt + 4'd1 == 4'(MAX_BURST);
  always_comb begin
    state_n = state;
    sel_n = sel;
    cnt_n = cnt;
    ptr_n = ptr;
    case (state)
      OWN: begin
        if (own_req) begin
          cnt_n = last ? 4'd0 : cnt + 4'd1;
          state_n = last && other ? SWITCH : OWN;
          sel_n = last && other ? 2'd3 : sel;
        end else begin
          state_n = other ? SWITCH : IDLE;
          sel_n = 2'd3;
        end
      end
      default: begin
        state_n = |req ? OWN : IDLE;
        sel_n = |req ? pick : 2'd3;
        cnt_n = 4'd0;
        ptr_n = |req ? (pick == 2'd2 ? 2'd0 : pick + 2'd1) : ptr;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 2'd0;
      cnt <= 4'd0;
      sel <= 2'd3;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      sel <= sel_n;
      out_valid <= own_req;
      out_data <= !own_req ? '0 : sel == 2'd0 ? port_a : sel == 2'd1 ? port_b : port_c;
    end
  end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: directed self-checking bench for mux_rr_sched
module tb_mux_rr_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] req;
  logic [7:0] port_a, port_b, port_c;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic [7:0] out_data;
  logic out_valid;
  int vec = 0;
  int err = 0;
  int seq [16];
  mux_rr_sched #(.DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .port_a(port_a), .port_b(port_b), .port_c(port_c),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] g_of(int s);
    return s == 3 ? 3'b000 : s == 0 ? 3'b001 : s == 1 ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [7:0] d_of(int s);
    return s == 0 ? 8'h11 : s == 1 ? 8'h22 : s == 2 ? 8'h33 : 8'h00;
  endfunction
  task automatic cs(input string tag, input logic [2:0] eg, input logic [1:0] es, input logic ev, input logic [7:0] ed);
    vec++;
    assert (gnt === eg) else begin err++; $error("FAIL %s gnt obs=%b exp=%b", tag, gnt, eg); end
    vec++;
    assert (sel === es) else begin err++; $error("FAIL %s sel obs=%b exp=%b", tag, sel, es); end
    vec++;
    assert (out_valid === ev) else begin err++; $error("FAIL %s out_valid obs=%b exp=%b", tag, out_valid, ev); end
    vec++;
    assert (out_data === ed) else begin err++; $error("FAIL %s out_data obs=%h exp=%h", tag, out_data, ed); end
  endtask
  initial begin
    rst_n = 1'b0;
    req = 3'b000;
    port_a = 8'h00;
    port_b = 8'h00;
    port_c = 8'h00;
    tick();
    tick();
    cs("rst", 3'b000, 2'd3, 1'b0, 8'h00);
    rst_n = 1'b1;
    req = 3'b001;
    port_a = 8'h5A;
    tick();
    cs("a_gnt", 3'b001, 2'd0, 1'b0, 8'h00);
    tick();
    cs("a_beat", 3'b001, 2'd0, 1'b1, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      tick();
      cs("a_hold", 3'b001, 2'd0, 1'b1, 8'h5A);
    end
    port_a = 8'hA5;
    tick();
    cs("a_data", 3'b001, 2'd0, 1'b1, 8'hA5);
    req = 3'b100;
    port_c = 8'hC3;
    tick();
    cs("ac_dead", 3'b000, 2'd3, 1'b0, 8'h00);
    tick();
    cs("c_gnt", 3'b100, 2'd2, 1'b0, 8'h00);
    tick();
    cs("c_beat", 3'b100, 2'd2, 1'b1, 8'hC3);
    req = 3'b000;
    tick();
    cs("c_drop", 3'b000, 2'd3, 1'b0, 8'h00);
    req = 3'b111;
    port_a = 8'h11;
    port_b = 8'h22;
    port_c = 8'h33;
    seq = '{0, 0, 0, 0, 3, 1, 1, 1, 1, 3, 2, 2, 2, 2, 3, 0};
    for (int i = 0; i < 16; i++) begin
      int prev;
      prev = i == 0 ? 3 : seq[i-1];
      tick();
      cs("rr", g_of(seq[i]), 2'(seq[i]), prev != 3, d_of(prev));
    end
    req = 3'b010;
    tick();
    cs("ab_dead", 3'b000, 2'd3, 1'b0, 8'h00);
    tick();
    cs("b_gnt", 3'b010, 2'd1, 1'b0, 8'h00);
    tick();
    cs("b_beat", 3'b010, 2'd1, 1'b1, 8'h22);
    req = 3'b000;
    tick();
    cs("b_drop", 3'b000, 2'd3, 1'b0, 8'h00);
    tick();
    cs("b_idle", 3'b000, 2'd3, 1'b0, 8'h00);
    req = 3'b010;
    tick();
    cs("b2_gnt", 3'b010, 2'd1, 1'b0, 8'h00);
    req = 3'b111;
    tick();
    cs("b2_beat", 3'b010, 2'd1, 1'b1, 8'h22);
    rst_n = 1'b0;
    tick();
    cs("b2_rst", 3'b000, 2'd3, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick();
    cs("post_rst_a", 3'b001, 2'd0, 1'b0, 8'h00);
    tick();
    cs("post_rst_beat", 3'b001, 2'd0, 1'b1, 8'h11);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
